topo_grid: RTL and testbench
============================

# topo_grid

Parametrised whack-a-mole playfield of `NUM_CELLS` mole cells, the clocked successor to the single combinational mole cell. It owns per-cell mole state and lifetime timers, cursor selection, strike detection, and hit/miss scoring. It drives one packed 3-bit colour per cell to the VGA tile renderer. It sits between the game controller (spawn requests, frame tick) and the VGA pixel path.

## Interface
- `NUM_CELLS`, 9: number of mole cells (1..16).
- `IDX_W`, 4: width of cell index buses; must satisfy 2^IDX_W ≥ NUM_CELLS.
- `LIFE_TICKS`, 60: ticks a mole stays up before escaping (≥1).
- `FLASH_TICKS`, 8: ticks a struck cell shows the hit colour (≥1).
- `SCORE_W`, 8: width of the score and miss counters.

Ports:
- `Clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `tick`  in  1  one-cycle timebase strobe (e.g. per frame); timers move only on tick.
- `spawn_valid`  in  1  request to raise a mole.
- `spawn_idx`  in  IDX_W  target cell of the spawn.
- `spawn_accept`  out  1  one-cycle pulse: previous-cycle spawn was taken.
- `cursor_idx`  in  IDX_W  currently selected cell; values ≥ NUM_CELLS select nothing.
- `golpe`  in  1  strike button level; synchronous to `Clock`.
- `hit`  out  1  one-cycle pulse per successful strike.
- `miss`  out  1  one-cycle pulse when ≥1 mole escaped.
- `score`  out  SCORE_W  saturating hit count.
- `misses`  out  SCORE_W  saturating escape count.
- `rgb`  out  3*NUM_CELLS  cell i colour at bits [3i+2:3i]; registered.

## Operation
- Each cell has a 3-state FSM, EMPTY / UP / STRUCK, plus a down-counter sized for max(LIFE_TICKS, FLASH_TICKS).
- EMPTY → UP: `spawn_valid` is high, `spawn_idx` < NUM_CELLS, and that cell is EMPTY at the edge. The counter loads LIFE_TICKS and `spawn_accept` pulses next cycle. Otherwise the spawn is dropped and `spawn_accept` stays 0.
- Strike event: rising edge of `golpe`, i.e. `golpe` && !`golpe_q`. `golpe_q` resets to 0, so `golpe` held high through reset release yields one strike on the first edge.
- UP → STRUCK: a strike while `cursor_idx` names this cell and it is UP.
  - The counter loads FLASH_TICKS.
  - `hit` pulses next cycle.
  - `score` increments by 1 and saturates at 2^SCORE_W−1.
- Strike on an EMPTY or STRUCK cell, or with `cursor_idx` out of range: no effect.
- UP → EMPTY (escape): on `tick` with counter == 1.
  - `misses` increases by the number of cells escaping that cycle, saturating.
  - `miss` pulses once if any cell escaped.
- STRUCK → EMPTY: on `tick` with counter == 1. Counters otherwise decrement by 1 on `tick` only.
- Colour per cell, with sel = (cursor_idx == i):
  - EMPTY, not sel: 010 (green).
  - EMPTY, sel: 001.
  - UP, not sel: 110.
  - UP, sel: 101.
  - STRUCK, any sel: 111.

## Timing
- Reset (async assert): all cells EMPTY, counters 0, `golpe_q`=0, `spawn_accept`/`hit`/`miss`=0, `score`=`misses`=0, `rgb` = all cells 010.
- All outputs are registered. State changes at edge k; `hit`, `miss`, `spawn_accept`, `score`, `misses` and `rgb` reflect them after edge k, with 1-cycle latency from the sampled inputs.
- The `rgb` cursor highlight follows `cursor_idx` with 1-cycle latency.
- A mole spawned at edge k escapes at the LIFE_TICKS-th `tick` sampled after edge k. A `tick` coincident with the spawn edge does not count.
- Simultaneous strike and escape on the same cell, same edge: the strike wins. Result is STRUCK, `hit`=1, and no miss is counted for that cell.
- Spawn and strike on the same EMPTY cell, same edge: the spawn takes effect and the strike whiffs, because strikes evaluate pre-edge state.
- Spawn to a cell leaving UP or STRUCK on that edge: dropped, since the cell is not EMPTY pre-edge.
- Saturated counters hold at all-ones. `hit` and `miss` still pulse.
- Reset asserted mid-lifetime: immediate return to reset values. No `miss` is generated.

## Test plan
- Reset, then spawn idx 4 → `spawn_accept`=1 for one cycle. Cell 4 `rgb`=110; it becomes 101 after `cursor_idx`=4.
- Cursor 4, `golpe` 0→1 held 5 cycles → exactly one `hit` pulse, `score`=1. Cell 4 = 111 for 8 ticks, then 010.
- LIFE_TICKS=3; spawn cells 0 and 2 on consecutive cycles, no strikes → 3rd tick expires both together: one `miss` pulse, `misses`=2.
- Strike edge coincident with the expiring tick on the cursor cell → `hit`=1, `miss`=0, `score`+1, `misses` unchanged.
- Spawn to an UP cell, to idx 12 (≥NUM_CELLS), and a strike with cursor 15 → no `spawn_accept`, no `hit`, no state change.
- SCORE_W=2: four hits → `score` holds 3 with a 4th `hit` pulse. Async `reset` mid-lifetime → all outputs at reset values before the next edge.

Source files
------------

// File: rtl/topo_grid.sv
// topo_grid: whack-a-mole playfield with per-cell mole lifetimes, cursor strikes, hit/miss scoring and per-cell colour
// Ports: Clock/reset (async active-high); tick timebase strobe; spawn_valid/spawn_idx -> spawn_accept;
// cursor_idx + golpe strike level -> hit; escapes -> miss; saturating score/misses; rgb packed 3 bits per cell.
module topo_grid #(
  parameter int NUM_CELLS   = 9,
  parameter int IDX_W       = 4,
  parameter int LIFE_TICKS  = 60,
  parameter int FLASH_TICKS = 8,
  parameter int SCORE_W     = 8
) (
  input  logic                   Clock,
  input  logic                   reset,
  input  logic                   tick,
  input  logic                   spawn_valid,
  input  logic [IDX_W-1:0]       spawn_idx,
  output logic                   spawn_accept,
  input  logic [IDX_W-1:0]       cursor_idx,
  input  logic                   golpe,
  output logic                   hit,
  output logic                   miss,
  output logic [SCORE_W-1:0]     score,
  output logic [SCORE_W-1:0]     misses,
  output logic [3*NUM_CELLS-1:0] rgb
);
  localparam int MAX_T = LIFE_TICKS > FLASH_TICKS ? LIFE_TICKS : FLASH_TICKS;
  localparam int CNT_W = $clog2(MAX_T + 1);
  localparam int SUM_W = SCORE_W + 6;
  localparam logic [SUM_W-1:0] SAT = SUM_W'({SCORE_W{1'b1}});
  typedef enum logic [1:0] {EMPTY, UP, STRUCK} cell_t;
  cell_t            st    [NUM_CELLS];
  cell_t            st_n  [NUM_CELLS];
  logic [CNT_W-1:0] cnt   [NUM_CELLS];
  logic [CNT_W-1:0] cnt_n [NUM_CELLS];
  logic                   golpe_q, strike, take, struck_any;
  logic [SUM_W-1:0]       esc, miss_sum, score_sum;
  logic [SCORE_W-1:0]     score_n, misses_n;
  logic [3*NUM_CELLS-1:0] rgb_n;
  assign strike = golpe & ~golpe_q;
  // Every decision uses pre-edge cell state, so a strike on a cell being spawned
  // this edge whiffs and a spawn to a cell that is just leaving UP/STRUCK is dropped.
  // The strike branch precedes the tick branch so a strike beats a same-edge escape.
  always_comb begin
    st_n = st;
    cnt_n = cnt;
    take = 1'b0;
    struck_any = 1'b0;
    esc = '0;
    rgb_n = '0;
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (st[i] == EMPTY && spawn_valid && spawn_idx == IDX_W'(i)) begin
        st_n[i] = UP;
        cnt_n[i] = CNT_W'(LIFE_TICKS);
        take = 1'b1;
      end else if (st[i] == UP && strike && cursor_idx == IDX_W'(i)) begin
        st_n[i] = STRUCK;
        cnt_n[i] = CNT_W'(FLASH_TICKS);
        struck_any = 1'b1;
      end else if (st[i] != EMPTY && tick) begin
        cnt_n[i] = cnt[i] - CNT_W'(1);
        if (cnt[i] == CNT_W'(1)) begin
          st_n[i] = EMPTY;
          esc = esc + SUM_W'(st[i] == UP);
        end
      end
      rgb_n[3*i +: 3] = st_n[i] == STRUCK ? 3'b111 :
                        st_n[i] == UP     ? (cursor_idx == IDX_W'(i) ? 3'b101 : 3'b110) :
                                            (cursor_idx == IDX_W'(i) ? 3'b001 : 3'b010);
    end
    miss_sum = SUM_W'(misses) + esc;
    score_sum = SUM_W'(score) + SUM_W'(struck_any);
    misses_n = miss_sum > SAT ? SAT[SCORE_W-1:0] : miss_sum[SCORE_W-1:0];
    score_n = score_sum > SAT ? SAT[SCORE_W-1:0] : score_sum[SCORE_W-1:0];
  end
  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      st <= '{default: EMPTY};
      cnt <= '{default: '0};
      golpe_q <= 1'b0;
      spawn_accept <= 1'b0;
      hit <= 1'b0;
      miss <= 1'b0;
      score <= '0;
      misses <= '0;
      rgb <= {NUM_CELLS{3'b010}};
    end else begin
      st <= st_n;
      cnt <= cnt_n;
      golpe_q <= golpe;
      spawn_accept <= take;
      hit <= struck_any;
      miss <= esc != '0;
      score <= score_n;
      misses <= misses_n;
      rgb <= rgb_n;
    end
  end
endmodule

// File: tb/tb_topo_grid.sv
// tb_topo_grid: randomized and directed checks of topo_grid against a tick-countdown model
module tb_topo_grid;
  localparam int NC = 9;
  localparam int LIFE = 3;
  localparam int FLASH = 8;
  localparam int SW = 3;
  localparam int MAXS = (1 << SW) - 1;
  bit clk = 0;
  logic reset = 1;
  logic tick = 0, spawn_valid = 0, golpe = 0;
  logic [3:0] spawn_idx = 0, cursor_idx = 15;
  logic spawn_accept, hit, miss;
  logic [SW-1:0] score, misses;
  logic [3*NC-1:0] rgb;
  int total = 0, bad = 0;
  topo_grid #(.NUM_CELLS(NC), .IDX_W(4), .LIFE_TICKS(LIFE), .FLASH_TICKS(FLASH), .SCORE_W(SW)) dut (
    .Clock(clk), .reset(reset), .tick(tick), .spawn_valid(spawn_valid), .spawn_idx(spawn_idx),
    .spawn_accept(spawn_accept), .cursor_idx(cursor_idx), .golpe(golpe), .hit(hit), .miss(miss),
    .score(score), .misses(misses), .rgb(rgb)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Model: each cell is described by ticks left as a mole (up_left) and ticks
  // left showing the hit colour (fl_left); a cell is empty when both are zero.
  int m_up [NC], m_fl [NC], n_up [NC], n_fl [NC];
  int m_score, m_misses, n_score, n_misses, n_esc;
  bit m_prev, n_strike, n_acc, n_hit, e_acc, e_hit, e_miss;
  logic [3*NC-1:0] n_rgb, e_rgb;
  always_comb begin
    n_up = m_up;
    n_fl = m_fl;
    n_acc = 0;
    n_hit = 0;
    n_esc = 0;
    n_rgb = '0;
    n_strike = golpe && !m_prev;
    for (int i = 0; i < NC; i++) begin
      if (m_up[i] > 0) begin
        if (n_strike && int'(cursor_idx) == i) begin
          n_up[i] = 0;
          n_fl[i] = FLASH;
          n_hit = 1;
        end else if (tick) begin
          n_up[i] = m_up[i] - 1;
          if (n_up[i] == 0) n_esc++;
        end
      end else if (m_fl[i] > 0) begin
        if (tick) n_fl[i] = m_fl[i] - 1;
      end else if (spawn_valid && int'(spawn_idx) == i) begin
        n_up[i] = LIFE;
        n_acc = 1;
      end
      n_rgb[3*i +: 3] = n_fl[i] > 0 ? 3'd7 : n_up[i] > 0 ? (int'(cursor_idx) == i ? 3'd5 : 3'd6)
                                                          : (int'(cursor_idx) == i ? 3'd1 : 3'd2);
    end
    n_score = m_score + int'(n_hit) > MAXS ? MAXS : m_score + int'(n_hit);
    n_misses = m_misses + n_esc > MAXS ? MAXS : m_misses + n_esc;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_up <= '{default: 0};
      m_fl <= '{default: 0};
      m_score <= 0;
      m_misses <= 0;
      m_prev <= 0;
      e_acc <= 0;
      e_hit <= 0;
      e_miss <= 0;
      e_rgb <= {NC{3'b010}};
    end else begin
      m_up <= n_up;
      m_fl <= n_fl;
      m_score <= n_score;
      m_misses <= n_misses;
      m_prev <= golpe;
      e_acc <= n_acc;
      e_hit <= n_hit;
      e_miss <= n_esc > 0;
      e_rgb <= n_rgb;
    end
  end
  always @(negedge clk) begin
    chk("spawn_accept", int'(spawn_accept), int'(e_acc));
    chk("hit", int'(hit), int'(e_hit));
    chk("miss", int'(miss), int'(e_miss));
    chk("score", int'(score), m_score);
    chk("misses", int'(misses), m_misses);
    chk("rgb", int'(rgb), int'(e_rgb));
  end
  task automatic reset_literals(input string tag);
    chk({tag, "_rgb"}, int'(rgb), int'({NC{3'b010}}));
    chk({tag, "_score"}, int'(score), 0);
    chk({tag, "_misses"}, int'(misses), 0);
    chk({tag, "_hit"}, int'(hit), 0);
    chk({tag, "_miss"}, int'(miss), 0);
    chk({tag, "_accept"}, int'(spawn_accept), 0);
  endtask
  initial begin
    @(negedge clk);
    reset_literals("rst");
    reset = 0;
    spawn_valid = 1;
    spawn_idx = 4;
    @(negedge clk);
    chk("d_accept", int'(spawn_accept), 1);
    chk("d_cell4_up", int'(rgb[14:12]), 6);
    spawn_valid = 0;
    cursor_idx = 4;
    @(negedge clk);
    chk("d_accept_pulse", int'(spawn_accept), 0);
    chk("d_cell4_sel", int'(rgb[14:12]), 5);
    golpe = 1;
    @(negedge clk);
    chk("d_hit", int'(hit), 1);
    chk("d_score1", int'(score), 1);
    chk("d_cell4_struck", int'(rgb[14:12]), 7);
    repeat (4) @(negedge clk);
    chk("d_hit_once", int'(hit), 0);
    chk("d_score_held", int'(score), 1);
    golpe = 0;
    cursor_idx = 15;
    tick = 1;
    repeat (7) @(negedge clk);
    chk("d_flash7", int'(rgb[14:12]), 7);
    @(negedge clk);
    chk("d_flash_done", int'(rgb[14:12]), 2);
    tick = 0;
    spawn_valid = 1;
    spawn_idx = 0;
    @(negedge clk);
    spawn_valid = 0;
    tick = 1;
    repeat (2) @(negedge clk);
    cursor_idx = 0;
    golpe = 1;
    @(negedge clk);
    chk("d_coinc_hit", int'(hit), 1);
    chk("d_coinc_miss", int'(miss), 0);
    chk("d_coinc_score", int'(score), 2);
    chk("d_coinc_misses", int'(misses), 0);
    chk("d_coinc_rgb", int'(rgb[2:0]), 7);
    golpe = 0;
    tick = 0;
    cursor_idx = 15;
    spawn_valid = 1;
    spawn_idx = 1;
    @(negedge clk);
    spawn_idx = 2;
    @(negedge clk);
    spawn_valid = 0;
    tick = 1;
    repeat (2) @(negedge clk);
    chk("d_pre_escape", int'(miss), 0);
    @(negedge clk);
    chk("d_escape_miss", int'(miss), 1);
    chk("d_escape_misses", int'(misses), 2);
    tick = 0;
    @(negedge clk);
    chk("d_escape_pulse", int'(miss), 0);
    spawn_valid = 1;
    spawn_idx = 12;
    @(negedge clk);
    chk("d_oob_spawn", int'(spawn_accept), 0);
    spawn_idx = 3;
    @(negedge clk);
    chk("d_spawn3", int'(spawn_accept), 1);
    @(negedge clk);
    chk("d_spawn_up", int'(spawn_accept), 0);
    spawn_valid = 0;
    golpe = 1;
    @(negedge clk);
    chk("d_oob_hit", int'(hit), 0);
    chk("d_oob_score", int'(score), 2);
    golpe = 0;
    spawn_valid = 1;
    spawn_idx = 5;
    @(negedge clk);
    spawn_valid = 0;
    @(negedge clk);
    #2 reset = 1;
    #1 reset_literals("async");
    #1 reset = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 299) == 0) begin
        #2 reset = 1;
        #1 reset = 0;
      end
      tick = $urandom_range(0, 2) == 0;
      spawn_valid = $urandom_range(0, 1) == 1;
      spawn_idx = 4'($urandom_range(0, 15));
      cursor_idx = 4'($urandom_range(0, 10));
      golpe = $urandom_range(0, 2) == 0;
    end
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
